// File: rtl/tone_seq_pkg.sv
// Shared types and helpers for the tone sequencer: FSM state, width helpers, divider calculator.
package tone_seq_pkg;

   localparam int unsigned CLK_HZ = 12_000_000;

   typedef enum logic {
      IDLE,
      PLAY
   } seq_state_t;

   // Index widths never collapse to zero so single-entry configurations still have a port bit.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned ch_w(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int unsigned div_for_hz(input int unsigned hz);
      if (hz == 0) return 0;
      return CLK_HZ / (2 * hz) - 1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchroniser, saturating low/high counters, one press pulse per debounced press.
module key_debounce #(
   parameter int unsigned DEB_TICKS = 120000
) (
   input  logic clk12MHz,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int unsigned   CW      = $clog2(DEB_TICKS + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);

   logic [1:0]    sync_q;
   logic [CW-1:0] low_cnt;
   logic [CW-1:0] high_cnt;
   logic          armed;

   // armed drops on a press and returns only after a fully debounced release.
   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         sync_q   <= '1;
         low_cnt  <= '0;
         high_cnt <= '0;
         armed    <= 1'b1;
         press    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_n};
         press  <= 1'b0;
         if (!sync_q[1]) begin
            high_cnt <= '0;
            if (low_cnt != DEB_MAX) begin
               low_cnt <= low_cnt + CW'(1);
               if ((low_cnt == DEB_MAX - CW'(1)) && armed) begin
                  press <= 1'b1;
                  armed <= 1'b0;
               end
            end
         end else begin
            low_cnt <= '0;
            if (high_cnt != DEB_MAX) begin
               high_cnt <= high_cnt + CW'(1);
               if (high_cnt == DEB_MAX - CW'(1)) armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-channel square-wave tone sequencer with writable step table and debounced start/stop key.
// Define TONE_SEQ_LOOP_EN to wrap playback after the last step instead of stopping.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter  int unsigned NUM_CH     = 2,
   parameter  int unsigned DIV_W      = 16,
   parameter  int unsigned SEQ_DEPTH  = 16,
   parameter  int unsigned STEP_TICKS = 3000000,
   parameter  int unsigned DEB_TICKS  = 120000,
   localparam int unsigned ADDR_W     = addr_w(SEQ_DEPTH),
   localparam int unsigned CH_W       = ch_w(NUM_CH)
) (
   input  logic              clk12MHz,
   input  logic              rst,
   input  logic              key_n,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DIV_W-1:0]  wr_div,
   input  logic [ADDR_W:0]   seq_len,
   output logic [NUM_CH-1:0] note,
   output logic              mix,
   output logic              p,
   output logic              n,
   output logic              playing,
   output logic [ADDR_W-1:0] step
);

   localparam int unsigned   TW        = $clog2(STEP_TICKS + 1);
   localparam logic [TW-1:0] STEP_LAST = TW'(STEP_TICKS - 1);
`ifdef TONE_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic              press;
   seq_state_t        state;
   logic [TW-1:0]     timer;
   logic              len_ok;
   logic              at_end;
   logic              last_step;
   logic              start;
   logic              stop;
   logic              advance;
   logic              load;
   logic [ADDR_W-1:0] load_idx;
   logic              wr_ok;

   logic [DIV_W-1:0] tbl [SEQ_DEPTH][NUM_CH];

   key_debounce #(
      .DEB_TICKS(DEB_TICKS)
   ) u_key_debounce (
      .clk12MHz(clk12MHz),
      .rst     (rst),
      .key_n   (key_n),
      .press   (press)
   );

   if (NUM_CH == (1 << CH_W)) begin : g_wr_full
      always_comb wr_ok = 1'b1;
   end else begin : g_wr_part
      always_comb wr_ok = (int'(wr_ch) < int'(NUM_CH));
   end

   always_ff @(posedge clk12MHz) begin
      if (wr_en && wr_ok) tbl[wr_addr][wr_ch] <= wr_div;
   end

   always_comb begin
      len_ok    = (seq_len != '0) && (seq_len <= (ADDR_W+1)'(SEQ_DEPTH));
      at_end    = (state == PLAY) && (timer == STEP_LAST);
      last_step = ({1'b0, step} + (ADDR_W+1)'(1)) >= seq_len;
      start     = (state == IDLE) && press && len_ok;
      stop      = (state == PLAY) && (press || (at_end && last_step && !LOOP));
      advance   = at_end && !press && !(last_step && !LOOP);
      load      = start || advance;
      load_idx  = (start || last_step) ? '0 : step + ADDR_W'(1);
   end

   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         state   <= IDLE;
         playing <= 1'b0;
         step    <= '0;
         timer   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= PLAY;
                  playing <= 1'b1;
                  step    <= '0;
                  timer   <= '0;
               end
            end
            PLAY: begin
               if (stop) begin
                  state   <= IDLE;
                  playing <= 1'b0;
                  step    <= '0;
                  timer   <= '0;
               end else if (advance) begin
                  step  <= load_idx;
                  timer <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               playing <= 1'b0;
               step    <= '0;
               timer   <= '0;
            end
         endcase
      end
   end

   // Active divider is latched at load, so table writes never disturb the tone in progress.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_W-1:0] div_q;
      logic [DIV_W-1:0] cnt_q;
      logic             note_q;

      always_ff @(posedge clk12MHz) begin
         if (rst || stop) begin
            div_q  <= '0;
            cnt_q  <= '0;
            note_q <= 1'b0;
         end else if (load) begin
            div_q  <= tbl[load_idx][c];
            cnt_q  <= tbl[load_idx][c];
            note_q <= 1'b0;
         end else if ((state == PLAY) && (div_q != '0)) begin
            if (cnt_q == '0) begin
               note_q <= ~note_q;
               cnt_q  <= div_q;
            end else begin
               cnt_q <= cnt_q - DIV_W'(1);
            end
         end
      end

      assign note[c] = note_q;
   end

   always_comb begin
      mix = ^note;
      p   = playing & mix;
      n   = playing & ~mix;
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer (DEB_TICKS=4, STEP_TICKS=40); honours TONE_SEQ_LOOP_EN.
module tb_tone_sequencer;
   import tone_seq_pkg::*;

   localparam int STEP = 40;
`ifdef TONE_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        key_n;
   logic        wr_en;
   logic        wr_ch;
   logic [3:0]  wr_addr;
   logic [15:0] wr_div;
   logic [4:0]  seq_len;
   logic [1:0]  note;
   logic        mix;
   logic        p;
   logic        n;
   logic        playing;
   logic [3:0]  step;

   int n_vec = 0;
   int n_err = 0;

   tone_sequencer #(
      .NUM_CH    (2),
      .DIV_W     (16),
      .SEQ_DEPTH (16),
      .STEP_TICKS(STEP),
      .DEB_TICKS (4)
   ) dut (
      .clk12MHz(clk),
      .rst     (rst),
      .key_n   (key_n),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_addr (wr_addr),
      .wr_div  (wr_div),
      .seq_len (seq_len),
      .note    (note),
      .mix     (mix),
      .p       (p),
      .n       (n),
      .playing (playing),
      .step    (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wr_tbl(input logic ch, input logic [3:0] addr, input logic [15:0] div);
      wr_ch   = ch;
      wr_addr = addr;
      wr_div  = div;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Playback state changes on the 7th edge after key_n falls; returns at the following negedge.
   task automatic key_press();
      key_n = 1'b0;
      repeat (7) @(negedge clk);
      key_n = 1'b1;
   endtask

   task automatic stop_if_loop();
      if (LOOP) begin
         key_press();
         check("loop_stop", playing, 0);
      end
      repeat (10) @(negedge clk);
   endtask

   // k=0 is the negedge right after playback starts; ch1 is always a rest.
   task automatic play_check(input int len, input int d0 [4], input bit inject, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         int s;
         int j;
         int dv;
         bit act;
         bit en;
         s   = k / STEP;
         j   = k % STEP;
         act = LOOP || (s < len);
         s   = s % len;
         dv  = d0[s];
         en  = act && (dv != 0) && (((j / (dv + 1)) % 2) == 1);
         check("playing", playing, act);
         check("step", step, act ? s : 0);
         check("note0", note[0], en);
         check("note1", note[1], 0);
         check("mix", mix, en);
         check("p", p, act && en);
         check("n", n, act && !en);
         wr_en = 1'b0;
         if (inject) begin
            case (k)
               10: begin wr_ch = 1'b0; wr_addr = 4'd0; wr_div = 16'd7; wr_en = 1'b1; end
               11: begin wr_ch = 1'b0; wr_addr = 4'd1; wr_div = 16'd2; wr_en = 1'b1; end
               39: begin wr_ch = 1'b0; wr_addr = 4'd1; wr_div = 16'd9; wr_en = 1'b1; end
               default: wr_en = 1'b0;
            endcase
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      key_n   = 1'b1;
      wr_en   = 1'b0;
      wr_ch   = 1'b0;
      wr_addr = '0;
      wr_div  = '0;
      seq_len = '0;
      repeat (3) @(negedge clk);
      check("rst_playing", playing, 0);
      check("rst_step", step, 0);
      check("rst_note", note, 0);
      check("rst_mix", mix, 0);
      check("rst_p", p, 0);
      check("rst_n", n, 0);
      check("div_for_hz", div_for_hz(1500000), 3);
      rst = 1'b0;
      @(negedge clk);

      // Bounce rejection, then a held press and single-step tone
      wr_tbl(1'b0, 4'd0, 16'd3);
      wr_tbl(1'b1, 4'd0, 16'd0);
      seq_len = 5'd1;
      for (int b = 0; b < 3; b++) begin
         key_n = 1'b0;
         repeat (3) @(negedge clk);
         key_n = 1'b1;
         repeat (3) @(negedge clk);
         check("bounce_idle", playing, 0);
      end
      repeat (6) @(negedge clk);
      check("bounce_idle_end", playing, 0);
      key_n = 1'b0;
      repeat (6) @(negedge clk);
      check("deb_early", playing, 0);
      @(negedge clk);
      check("deb_press", playing, 1);
      key_n = 1'b1;
      play_check(1, '{3, 0, 0, 0}, 1'b0, STEP + 2);
      stop_if_loop();

      // Three steps with distinct dividers
      wr_tbl(1'b0, 4'd0, 16'd1);
      wr_tbl(1'b0, 4'd1, 16'd2);
      wr_tbl(1'b0, 4'd2, 16'd5);
      wr_tbl(1'b1, 4'd1, 16'd0);
      wr_tbl(1'b1, 4'd2, 16'd0);
      seq_len = 5'd3;
      key_press();
      play_check(3, '{1, 2, 5, 0}, 1'b0, 3 * STEP + 2);
      stop_if_loop();

      // Press during step 1 stops at once
      key_press();
      repeat (50) @(negedge clk);
      check("mid_step", step, 1);
      check("mid_playing", playing, 1);
      key_press();
      check("stop_playing", playing, 0);
      check("stop_step", step, 0);
      check("stop_note", note, 0);
      check("stop_p", p, 0);
      check("stop_n", n, 0);
      repeat (10) @(negedge clk);

      // Press pulse coincides with the step-0 boundary edge
      key_press();
      repeat (33) @(negedge clk);
      check("pre_bnd_step", step, 0);
      check("pre_bnd_playing", playing, 1);
      key_press();
      check("bnd_playing", playing, 0);
      check("bnd_step", step, 0);
      check("bnd_note", note, 0);
      repeat (10) @(negedge clk);

      // Invalid lengths ignore the press
      seq_len = 5'd0;
      key_press();
      repeat (3) @(negedge clk);
      check("len0_idle", playing, 0);
      repeat (10) @(negedge clk);
      seq_len = 5'd17;
      key_press();
      repeat (3) @(negedge clk);
      check("len17_idle", playing, 0);
      repeat (10) @(negedge clk);

      // Table writes while playing, including a write on the load edge
      wr_tbl(1'b0, 4'd0, 16'd3);
      wr_tbl(1'b0, 4'd1, 16'd1);
      seq_len = 5'd2;
      key_press();
      play_check(2, '{3, 2, 0, 0}, 1'b1, LOOP ? 2 * STEP : 2 * STEP + 2);
      stop_if_loop();

      // Reset mid-step
      wr_tbl(1'b0, 4'd0, 16'd3);
      seq_len = 5'd1;
      key_press();
      repeat (20) @(negedge clk);
      check("pre_rst_note0", note[0], 1);
      check("pre_rst_playing", playing, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_playing", playing, 0);
      check("mid_rst_step", step, 0);
      check("mid_rst_note", note, 0);
      check("mid_rst_p", p, 0);
      check("mid_rst_n", n, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // One-shot vs wrap over two steps
      wr_tbl(1'b0, 4'd0, 16'd1);
      wr_tbl(1'b0, 4'd1, 16'd2);
      seq_len = 5'd2;
      key_press();
      play_check(2, '{1, 2, 0, 0}, 1'b0, 4 * STEP + 10);
      stop_if_loop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
